car_position_sequencer: RTL and testbench

- Upstream stage of the collision detector. Holds the position and orientation table for all cars.
- On each frame tick it advances every active car by a fixed step, wrapping at the screen edge.
- It then streams the cars one per cycle as (carIndex, carX, carY, carOrient) with a valid strobe.
- The collision detector and the display logic consume this stream.

---
 rtl/car_position_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_car_position_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/car_position_sequencer.sv
// Car position table: advances every active car once per frame tick, then streams all slots one per cycle.
// Optional CAR_FREEZE_EN adds a freeze input that suppresses movement for the frame it is sampled on.
module car_position_sequencer #(
  parameter int NUM_CARS = 12,
  parameter int X_MAX    = 640,
  parameter int Y_MAX    = 480,
  parameter int SPEED    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       spawn_valid,
  output logic       spawn_ready,
  input  logic [3:0] spawn_index,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic [1:0] spawn_orient,
`ifdef CAR_FREEZE_EN
  input  logic       freeze,
`endif
  output logic [9:0] carX,
  output logic [9:0] carY,
  output logic [1:0] carOrient,
  output logic [3:0] carIndex,
  output logic       car_valid,
  output logic       scan_done,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_STREAM, S_DONE} state_t;

  localparam logic [3:0]  LAST_IDX = 4'(NUM_CARS - 1);
  localparam logic [10:0] STEP     = 11'(SPEED);
  localparam logic [10:0] XLIM     = 11'(X_MAX);
  localparam logic [10:0] YLIM     = 11'(Y_MAX);

  state_t     r_state;
  logic [9:0] r_x      [NUM_CARS];
  logic [9:0] r_y      [NUM_CARS];
  logic [1:0] r_orient [NUM_CARS];
  logic [3:0] r_idx;
  logic       r_pending;
  logic       r_from_pending;

  logic        w_frozen;
  logic        w_start;
  logic        w_spawn_ok;
  logic [9:0]  w_cur_x;
  logic [9:0]  w_cur_y;
  logic [1:0]  w_cur_o;
  logic [10:0] w_x_sum;
  logic [10:0] w_y_sum;
  logic [9:0]  w_x_new;
  logic [9:0]  w_y_new;

  assign w_start    = frame_tick || r_pending;
  assign w_spawn_ok = spawn_valid && spawn_ready && (int'(spawn_index) < NUM_CARS);

`ifdef CAR_FREEZE_EN
  logic r_freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_freeze <= 1'b0;
    end else if (r_state == S_IDLE && w_start) begin
      r_freeze <= freeze;
    end
  end

  assign w_frozen = r_freeze;
`else
  assign w_frozen = 1'b0;
`endif

  // Next position of the slot selected by r_idx; sums are 11 bits so the wrap test cannot overflow.
  always_comb begin
    w_cur_x = r_x[r_idx];
    w_cur_y = r_y[r_idx];
    w_cur_o = r_orient[r_idx];
    w_x_sum = {1'b0, w_cur_x} + STEP;
    w_y_sum = {1'b0, w_cur_y} + STEP;
    w_x_new = w_cur_x;
    w_y_new = w_cur_y;
    if (!w_frozen) begin
      if (w_cur_o == 2'd2) begin
        w_x_new = (w_x_sum >= XLIM) ? 10'(w_x_sum - XLIM) : w_x_sum[9:0];
      end
      if (w_cur_o == 2'd1) begin
        w_y_new = (w_y_sum >= YLIM) ? 10'(w_y_sum - YLIM) : w_y_sum[9:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_pending      <= 1'b0;
      r_from_pending <= 1'b0;
      spawn_ready    <= 1'b1;
      carX           <= '0;
      carY           <= '0;
      carOrient      <= '0;
      carIndex       <= '0;
      car_valid      <= 1'b0;
      scan_done      <= 1'b0;
      busy           <= 1'b0;
      for (int i = 0; i < NUM_CARS; i++) begin
        r_x[i]      <= '0;
        r_y[i]      <= '0;
        r_orient[i] <= '0;
      end
    end else begin
      if (w_spawn_ok) begin
        r_x[spawn_index]      <= spawn_x;
        r_y[spawn_index]      <= spawn_y;
        r_orient[spawn_index] <= spawn_orient;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state        <= S_UPDATE;
            r_idx          <= '0;
            r_from_pending <= r_pending;
            busy           <= 1'b1;
            spawn_ready    <= 1'b0;
          end
        end

        S_UPDATE: begin
          if (frame_tick) r_pending <= 1'b1;
          r_x[r_idx] <= w_x_new;
          r_y[r_idx] <= w_y_new;
          if (r_idx == LAST_IDX) begin
            // Slot 0 is loaded here so car_valid rises the cycle after the last update;
            // the bypass only matters for a single-slot table.
            r_state   <= S_STREAM;
            car_valid <= 1'b1;
            carIndex  <= '0;
            carX      <= (r_idx == 4'd0) ? w_x_new : r_x[0];
            carY      <= (r_idx == 4'd0) ? w_y_new : r_y[0];
            carOrient <= r_orient[0];
            r_idx     <= (NUM_CARS > 1) ? 4'd1 : 4'd0;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end

        S_STREAM: begin
          if (frame_tick) r_pending <= 1'b1;
          if (carIndex == LAST_IDX) begin
            r_state   <= S_DONE;
            car_valid <= 1'b0;
            scan_done <= 1'b1;
          end else begin
            carIndex  <= r_idx;
            carX      <= r_x[r_idx];
            carY      <= r_y[r_idx];
            carOrient <= r_orient[r_idx];
            if (r_idx != LAST_IDX) r_idx <= r_idx + 4'd1;
          end
        end

        S_DONE: begin
          // A pending-sourced frame consumes the pending tick; ticks seen meanwhile were dropped.
          if (r_from_pending) begin
            r_pending <= 1'b0;
          end else if (frame_tick) begin
            r_pending <= 1'b1;
          end
          r_state     <= S_IDLE;
          scan_done   <= 1'b0;
          busy        <= 1'b0;
          spawn_ready <= 1'b1;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_car_position_sequencer.sv
// Self-checking bench for car_position_sequencer: directed and random frames against a modulo-arithmetic table model.
module tb_car_position_sequencer;

  localparam int NUM_CARS = 12;
  localparam int X_MAX    = 640;
  localparam int Y_MAX    = 480;
  localparam int SPEED    = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       spawn_valid = 1'b0;
  logic [3:0] spawn_index = '0;
  logic [9:0] spawn_x = '0;
  logic [9:0] spawn_y = '0;
  logic [1:0] spawn_orient = '0;
`ifdef CAR_FREEZE_EN
  logic       freeze = 1'b0;
`endif
  logic       spawn_ready;
  logic [9:0] carX;
  logic [9:0] carY;
  logic [1:0] carOrient;
  logic [3:0] carIndex;
  logic       car_valid;
  logic       scan_done;
  logic       busy;

  car_position_sequencer #(
    .NUM_CARS(NUM_CARS), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .SPEED(SPEED)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_index(spawn_index), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .spawn_orient(spawn_orient),
`ifdef CAR_FREEZE_EN
    .freeze(freeze),
`endif
    .carX(carX), .carY(carY), .carOrient(carOrient), .carIndex(carIndex),
    .car_valid(car_valid), .scan_done(scan_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int mx [NUM_CARS];
  int my [NUM_CARS];
  int mo [NUM_CARS];
  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NUM_CARS; i++) begin
      mx[i] = 0; my[i] = 0; mo[i] = 0;
    end
  endfunction

  function automatic void model_spawn(int idx, int x, int y, int o);
    if (idx < NUM_CARS) begin
      mx[idx] = x; my[idx] = y; mo[idx] = o;
    end
  endfunction

  function automatic void model_advance();
    for (int i = 0; i < NUM_CARS; i++) begin
      if (mo[i] == 1) my[i] = (my[i] + SPEED) % Y_MAX;
      else if (mo[i] == 2) mx[i] = (mx[i] + SPEED) % X_MAX;
    end
  endfunction

  task automatic do_spawn(input int idx, input int x, input int y, input int o);
    spawn_valid  = 1'b1;
    spawn_index  = 4'(idx);
    spawn_x      = 10'(x);
    spawn_y      = 10'(y);
    spawn_orient = 2'(o);
    n_checks++;
    if (spawn_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL spawn_ready_idle: got %b expected 1", spawn_ready);
    end
    step();
    spawn_valid = 1'b0;
    model_spawn(idx, x, y, o);
    $display("spawn slot %0d at (%0d,%0d) orient %0d", idx, x, y, o);
  endtask

  // Starts a frame from IDLE and checks every cycle until busy has dropped.
  task automatic check_frame(input bit with_spawn, input int s_idx, input int s_x, input int s_y,
                             input int s_o, input bit busy_spawn, input bit frz);
    int ci;
    bit exp_valid;
    frame_tick = 1'b1;
    if (with_spawn) begin
      spawn_valid  = 1'b1;
      spawn_index  = 4'(s_idx);
      spawn_x      = 10'(s_x);
      spawn_y      = 10'(s_y);
      spawn_orient = 2'(s_o);
      model_spawn(s_idx, s_x, s_y, s_o);
    end
`ifdef CAR_FREEZE_EN
    freeze = frz;
`endif
    if (!frz) model_advance();
    for (int c = 1; c <= 2 * NUM_CARS + 2; c++) begin
      step();
      frame_tick  = 1'b0;
      spawn_valid = 1'b0;
`ifdef CAR_FREEZE_EN
      freeze = 1'b0;
`endif
      if (busy_spawn && c == 2) begin
        spawn_valid  = 1'b1;
        spawn_index  = 4'd2;
        spawn_x      = 10'($urandom_range(0, X_MAX - 1));
        spawn_y      = 10'($urandom_range(0, Y_MAX - 1));
        spawn_orient = 2'd2;
      end
      exp_valid = (c >= NUM_CARS + 1) && (c <= 2 * NUM_CARS);
      n_checks++;
      if (car_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL car_valid c=%0d: got %b expected %b", c, car_valid, exp_valid);
      end
      n_checks++;
      if (scan_done !== (c == 2 * NUM_CARS + 1)) begin
        n_fail++;
        $display("FAIL scan_done c=%0d: got %b expected %b", c, scan_done, (c == 2 * NUM_CARS + 1));
      end
      n_checks++;
      if (busy !== (c <= 2 * NUM_CARS + 1) || spawn_ready !== (c > 2 * NUM_CARS + 1)) begin
        n_fail++;
        $display("FAIL busy_ready c=%0d: got busy=%b ready=%b expected busy=%b", c, busy, spawn_ready,
                 (c <= 2 * NUM_CARS + 1));
      end
      ci = exp_valid ? (c - NUM_CARS - 1) : ((c > 2 * NUM_CARS) ? NUM_CARS - 1 : -1);
      if (ci >= 0) begin
        n_checks++;
        if (carIndex !== 4'(ci) || carX !== 10'(mx[ci]) || carY !== 10'(my[ci]) ||
            carOrient !== 2'(mo[ci])) begin
          n_fail++;
          $display("FAIL stream c=%0d: got idx=%0d x=%0d y=%0d o=%0d expected idx=%0d x=%0d y=%0d o=%0d",
                   c, carIndex, carX, carY, carOrient, ci, mx[ci], my[ci], mo[ci]);
        end
      end
    end
    n_frames++;
    $display("frame %0d checked (spawn=%0b busy_spawn=%0b freeze=%0b)", n_frames, with_spawn, busy_spawn, frz);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if (car_valid !== 1'b0 || scan_done !== 1'b0 || busy !== 1'b0 || spawn_ready !== 1'b1 ||
        carX !== 10'd0 || carY !== 10'd0 || carIndex !== 4'd0 || carOrient !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%b b=%b r=%b x=%0d y=%0d i=%0d o=%0d expected 0/0/0/1/0/0/0/0",
               car_valid, scan_done, busy, spawn_ready, carX, carY, carIndex, carOrient);
    end
    rst = 1'b0;
    model_clear();
    step();
    do_spawn(1, 50, 60, 2);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (NUM_CARS + 3) step();
    n_checks++;
    if (car_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_stream: got v=%b b=%b expected 1/1", car_valid, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (car_valid !== 1'b0 || scan_done !== 1'b0 || busy !== 1'b0 || spawn_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b d=%b b=%b r=%b expected 0/0/0/1",
               car_valid, scan_done, busy, spawn_ready);
    end
    model_clear();
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (scan_done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL aborted_frame c=%0d: got d=%b b=%b expected 0/0", c, scan_done, busy);
      end
    end
    check_frame(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_spawn_stream();
    do_spawn(3, 100, 200, 1);
    check_frame(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    do_spawn(5, X_MAX - 1, 17, 2);
    do_spawn(6, 33, Y_MAX - 1, 1);
    do_spawn(15, 1, 1, 1);
    check_frame(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_spawn_busy();
    do_spawn(2, 400, 300, 1);
    check_frame(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
    check_frame(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_spawn_with_tick();
    check_frame(1'b1, 8, 250, 123, 2, 1'b0, 1'b0);
    check_frame(1'b1, 9, 77, Y_MAX - 1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int s1x [NUM_CARS];
    int s1y [NUM_CARS];
    int s1o [NUM_CARS];
    int ci;
    bit in1, in2, exp_valid, exp_done, exp_busy;
    model_advance();
    s1x = mx; s1y = my; s1o = mo;
    model_advance();
    frame_tick = 1'b1;
    for (int c = 1; c <= 2 * (2 * NUM_CARS + 1) + 3; c++) begin
      step();
      frame_tick = (c == 3 || c == 5);
      in1 = (c >= NUM_CARS + 1) && (c <= 2 * NUM_CARS);
      in2 = (c >= 3 * NUM_CARS + 3) && (c <= 4 * NUM_CARS + 2);
      exp_valid = in1 || in2;
      exp_done  = (c == 2 * NUM_CARS + 1) || (c == 4 * NUM_CARS + 3);
      exp_busy  = (c <= 2 * NUM_CARS + 1) || (c >= 2 * NUM_CARS + 3 && c <= 4 * NUM_CARS + 3);
      n_checks++;
      if (car_valid !== exp_valid || scan_done !== exp_done || busy !== exp_busy) begin
        n_fail++;
        $display("FAIL back_to_back c=%0d: got v=%b d=%b b=%b expected v=%b d=%b b=%b",
                 c, car_valid, scan_done, busy, exp_valid, exp_done, exp_busy);
      end
      if (exp_valid) begin
        ci = in1 ? (c - NUM_CARS - 1) : (c - 3 * NUM_CARS - 3);
        n_checks++;
        if (in1 && (carIndex !== 4'(ci) || carX !== 10'(s1x[ci]) || carY !== 10'(s1y[ci]) ||
                    carOrient !== 2'(s1o[ci]))) begin
          n_fail++;
          $display("FAIL b2b_frame1 c=%0d: got idx=%0d x=%0d y=%0d expected idx=%0d x=%0d y=%0d",
                   c, carIndex, carX, carY, ci, s1x[ci], s1y[ci]);
        end else if (in2 && (carIndex !== 4'(ci) || carX !== 10'(mx[ci]) || carY !== 10'(my[ci]) ||
                             carOrient !== 2'(mo[ci]))) begin
          n_fail++;
          $display("FAIL b2b_frame2 c=%0d: got idx=%0d x=%0d y=%0d expected idx=%0d x=%0d y=%0d",
                   c, carIndex, carX, carY, ci, mx[ci], my[ci]);
        end
      end
    end
    frame_tick = 1'b0;
    n_frames += 2;
    $display("back-to-back ticks: two frames checked");
  endtask

  task automatic test_random();
    int idx, o;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        idx = int'($urandom_range(0, 15));
        o   = int'($urandom_range(0, 3));
        do_spawn(idx, int'($urandom_range(0, X_MAX - 1)), int'($urandom_range(0, Y_MAX - 1)), o);
      end
      if (r[0]) begin
        check_frame(1'b1, int'($urandom_range(0, NUM_CARS - 1)), int'($urandom_range(0, X_MAX - 1)),
                    int'($urandom_range(0, Y_MAX - 1)), int'($urandom_range(1, 2)), 1'b0, 1'b0);
      end else begin
        check_frame(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
      end
    end
  endtask

`ifdef CAR_FREEZE_EN
  task automatic test_freeze();
    do_spawn(7, 300, 301, 2);
    do_spawn(10, 20, 21, 1);
    check_frame(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
    check_frame(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_spawn_stream();
    test_wrap();
    test_spawn_busy();
    test_spawn_with_tick();
    test_back_to_back();
    test_random();
`ifdef CAR_FREEZE_EN
    test_freeze();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
